fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program counter and instruction-fetch address generator sitting directly upstream of the decoder.
- Consumes the decoder's 3-bit pc control code (set / output / lock) and drives the memory address for the next instruction or argument word.
- Loads jump targets from the data bus.
- Performs single-level hardware interrupt entry and return: saves the PC to a shadow register, vectors, then restores.

Parameters:
- ADDR_W, 16, PC and address width.
- RESET_VECTOR, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_pc_control_code  in  3  [0] set, [1] output enable, [2] lock (decoder encoding).
- i_data_bus  in  16  jump target, sampled when set is accepted.
- i_mem_ready  in  1  memory accepted the current fetch address this cycle.
- i_interrupt  in  1  hardware interrupt request, sampled per cycle.
- i_int_vector  in  16  interrupt entry address.
- i_int_return  in  1  return-from-interrupt request.
- o_addr_bus  out  16  fetch address (always equals PC).
- o_addr_valid  out  1  fetch request.
- o_pc  out  16  current PC.
- o_int_active  out  1  interrupt in service (shadow occupied).
- o_int_dropped  out  1  one-cycle pulse: an interrupt was ignored.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_VECTOR, shadow=0.
  - State=RUN, o_addr_valid=0, o_int_active=0, o_int_dropped=0.
  - First fetch may be requested the cycle after rst deasserts.
- States: RUN, BUBBLE. BUBBLE lasts exactly one cycle and always returns to RUN.
- In BUBBLE:
  - o_addr_valid=0.
  - Set, increment, interrupt and return are all ignored.
  - An interrupt arriving in BUBBLE raises o_int_dropped.
- In RUN: o_addr_valid = code[1] & ~code[2]. o_addr_bus = PC, combinational, no extra latency.
- Per rising edge in RUN, highest priority first:
  1. Interrupt. Condition: i_interrupt=1 and o_int_active=0.
     - Shadow is loaded with the PC that rules 3-5 would have produced this edge.
     - PC=i_int_vector, o_int_active=1, next state BUBBLE.
     - Interrupt overrides lock. Any unaccepted fetch is abandoned.
  2. Return. Condition: i_int_return=1 and o_int_active=1.
     - PC=shadow, o_int_active=0, next state BUBBLE.
     - Return while o_int_active=0 is ignored.
  3. Lock. Condition: code[2]=1. PC held; set is ignored.
  4. Set. Condition: code[0]=1. PC=i_data_bus. This replaces any increment in the same cycle.
  5. Increment. Condition: o_addr_valid & i_mem_ready. PC=PC+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  6. Otherwise PC is held. A request with o_addr_valid=1 and i_mem_ready=0 keeps o_addr_bus stable until accepted or preempted by rule 1, 2 or 4.
- Interrupt rules:
  - i_interrupt=1 while o_int_active=1 is not serviced. o_int_dropped pulses high for that cycle (registered, visible the next cycle). No queuing.
  - Simultaneous i_interrupt and i_int_return while active: return is taken and the interrupt is dropped (pulse).
- Outputs: o_pc and o_int_active are registered. o_addr_valid is combinational from state and code.
- Reset mid-fetch or mid-BUBBLE returns immediately to reset values. No partial shadow update survives.

Decomposition:
- Shared package (pc_pkg):
  - state encoding RUN/BUBBLE;
  - bit indices PC_SET=0, PC_OUT=1, PC_LOCK=2;
  - ADDR_W;
  - default RESET_VECTOR.
- The decoder includes the same bit-index constants.
- No sub-module is required. The next-PC priority mux stays inline so that the shadow-capture value and the PC update come from a single expression.

Test Plan:
- Reset then code=3'b010, i_mem_ready=1 for 4 cycles -> o_addr_bus 0000,0001,0002,0003; o_addr_valid=1 throughout.
- PC=0005, code=3'b010, i_mem_ready=0 for 3 cycles then 1 -> o_addr_bus holds 0005 for 3 cycles, then 0006.
- PC=0010, code=3'b011, i_data_bus=1234, i_mem_ready=1 -> PC=1234 (no increment). Then code=3'b110 with i_data_bus=5555 -> PC stays 1234, o_addr_valid=0.
- PC=0020, code=3'b010, i_mem_ready=1, i_interrupt=1, i_int_vector=0100 -> PC=0100, shadow=0021, one bubble cycle with o_addr_valid=0, o_int_active=1. Later i_int_return=1 -> PC=0021, o_int_active=0, bubble.
- Interrupt while o_int_active=1, and i_interrupt+i_int_return in the same cycle -> o_int_dropped pulses once each time; the return restores shadow; the vector is not taken.
- PC=FFFF accepted fetch -> PC=0000. Assert rst during BUBBLE after an interrupt -> PC=RESET_VECTOR, o_int_active=0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter definitions: fetch FSM states, decoder pc control bit
// positions and address-width defaults. The decoder uses the same bit indices.
package pc_pkg;

    localparam int PC_ADDR_W = 16;
    localparam logic [PC_ADDR_W-1:0] DEF_RESET_VECTOR = 16'h0000;

    // Bit positions inside the decoder's 3-bit pc control code
    localparam int PC_SET  = 0;
    localparam int PC_OUT  = 1;
    localparam int PC_LOCK = 2;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Program counter and fetch-address generator with single-level interrupt
// entry/return through a shadow PC register.
module fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        i_pc_control_code,
    input  logic [ADDR_W-1:0] i_data_bus,
    input  logic              i_mem_ready,
    input  logic              i_interrupt,
    input  logic [ADDR_W-1:0] i_int_vector,
    input  logic              i_int_return,
    output logic [ADDR_W-1:0] o_addr_bus,
    output logic              o_addr_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_int_active,
    output logic              o_int_dropped
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] shadow_q, shadow_d;
    logic              int_active_q, int_active_d;
    logic              int_dropped_q, int_dropped_d;
    logic [ADDR_W-1:0] seq_pc;
    logic              addr_valid;

    // Held low during reset so no request escapes while rst is asserted
    assign addr_valid = (state_q == RUN) & i_pc_control_code[PC_OUT]
                      & ~i_pc_control_code[PC_LOCK] & ~rst;

    assign o_addr_bus    = pc_q;
    assign o_addr_valid  = addr_valid;
    assign o_pc          = pc_q;
    assign o_int_active  = int_active_q;
    assign o_int_dropped = int_dropped_q;

    // seq_pc is the lock/set/increment/hold result; it feeds both the normal
    // PC update and the shadow capture so the saved return address is exact.
    always_comb begin
        seq_pc        = pc_q;
        state_d       = state_q;
        pc_d          = pc_q;
        shadow_d      = shadow_q;
        int_active_d  = int_active_q;
        int_dropped_d = i_interrupt & ((state_q == BUBBLE) | int_active_q);

        if (i_pc_control_code[PC_LOCK])
            seq_pc = pc_q;
        else if (i_pc_control_code[PC_SET])
            seq_pc = i_data_bus;
        else if (addr_valid && i_mem_ready)
            seq_pc = pc_q + 1'b1;

        case (state_q)
            RUN: begin
                if (i_interrupt && !int_active_q) begin
                    shadow_d     = seq_pc;
                    pc_d         = i_int_vector;
                    int_active_d = 1'b1;
                    state_d      = BUBBLE;
                end else if (i_int_return && int_active_q) begin
                    pc_d         = shadow_q;
                    int_active_d = 1'b0;
                    state_d      = BUBBLE;
                end else begin
                    pc_d = seq_pc;
                end
            end
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            shadow_q      <= '0;
            int_active_q  <= 1'b0;
            int_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            shadow_q      <= shadow_d;
            int_active_q  <= int_active_d;
            int_dropped_q <= int_dropped_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch/stall/set/lock, interrupt entry and
// return, dropped-interrupt pulses, PC wrap and reset during a bubble.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  code;
    logic [15:0] data_bus;
    logic        mem_ready;
    logic        interrupt;
    logic [15:0] int_vector;
    logic        int_return;
    logic [15:0] addr_bus;
    logic        addr_valid;
    logic [15:0] pc;
    logic        int_active;
    logic        int_dropped;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.ADDR_W(16), .RESET_VECTOR(16'h0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pc_control_code(code),
        .i_data_bus       (data_bus),
        .i_mem_ready      (mem_ready),
        .i_interrupt      (interrupt),
        .i_int_vector     (int_vector),
        .i_int_return     (int_return),
        .o_addr_bus       (addr_bus),
        .o_addr_valid     (addr_valid),
        .o_pc             (pc),
        .o_int_active     (int_active),
        .o_int_dropped    (int_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; code = 3'b000; data_bus = '0; mem_ready = 1'b0;
        interrupt = 1'b0; int_vector = '0; int_return = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_active", {15'd0, int_active}, 16'd0);
        chk("rst_valid", {15'd0, addr_valid}, 16'd0);
        chk("rst_dropped", {15'd0, int_dropped}, 16'd0);

        // sequential fetch
        rst = 1'b0; code = 3'b010; mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", addr_bus, 16'(i));
            chk("seq_valid", {15'd0, addr_valid}, 16'd1);
            tick();
        end
        chk("seq_end", pc, 16'h0004);
        tick();
        chk("pc5", pc, 16'h0005);

        // stall on mem_ready=0
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", addr_bus, 16'h0005);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        chk("stall_release", addr_bus, 16'h0006);

        // set overrides increment; lock holds and ignores set
        code = 3'b001; data_bus = 16'h0010;
        tick();
        chk("set_0010", pc, 16'h0010);
        code = 3'b011; data_bus = 16'h1234; mem_ready = 1'b1;
        tick();
        chk("set_no_inc", pc, 16'h1234);
        code = 3'b110; data_bus = 16'h5555;
        #1;
        chk("lock_valid", {15'd0, addr_valid}, 16'd0);
        tick();
        chk("lock_hold", pc, 16'h1234);

        // interrupt entry with accepted fetch: shadow gets 0021
        code = 3'b001; data_bus = 16'h0020;
        tick();
        chk("set_0020", pc, 16'h0020);
        code = 3'b010; mem_ready = 1'b1; interrupt = 1'b1; int_vector = 16'h0100;
        tick();
        interrupt = 1'b0;
        #1;
        chk("int_pc", pc, 16'h0100);
        chk("int_active", {15'd0, int_active}, 16'd1);
        chk("int_bubble_valid", {15'd0, addr_valid}, 16'd0);
        chk("int_no_drop", {15'd0, int_dropped}, 16'd0);
        tick();
        chk("bubble_no_inc", pc, 16'h0100);
        chk("run_valid", {15'd0, addr_valid}, 16'd1);
        code = 3'b000; int_return = 1'b1;
        tick();
        int_return = 1'b0; code = 3'b010;
        #1;
        chk("ret_pc", pc, 16'h0021);
        chk("ret_active", {15'd0, int_active}, 16'd0);
        chk("ret_bubble_valid", {15'd0, addr_valid}, 16'd0);
        code = 3'b000;
        tick();
        chk("ret_after_bubble", pc, 16'h0021);

        // nested interrupt dropped
        interrupt = 1'b1; int_vector = 16'h0200;
        tick();
        interrupt = 1'b0;
        chk("int2_pc", pc, 16'h0200);
        tick();
        interrupt = 1'b1; int_vector = 16'h0300;
        tick();
        interrupt = 1'b0;
        chk("nest_drop", {15'd0, int_dropped}, 16'd1);
        chk("nest_pc", pc, 16'h0200);
        chk("nest_active", {15'd0, int_active}, 16'd1);
        tick();
        chk("nest_drop_clear", {15'd0, int_dropped}, 16'd0);

        // simultaneous interrupt + return: return wins, interrupt dropped
        interrupt = 1'b1; int_return = 1'b1;
        tick();
        int_return = 1'b0;
        chk("sim_pc", pc, 16'h0021);
        chk("sim_active", {15'd0, int_active}, 16'd0);
        chk("sim_drop", {15'd0, int_dropped}, 16'd1);
        // interrupt still high during the bubble: dropped again, not taken
        tick();
        interrupt = 1'b0;
        chk("bubble_drop", {15'd0, int_dropped}, 16'd1);
        chk("bubble_int_active", {15'd0, int_active}, 16'd0);
        chk("bubble_int_pc", pc, 16'h0021);
        tick();
        chk("drop_clear", {15'd0, int_dropped}, 16'd0);

        // PC wrap
        code = 3'b001; data_bus = 16'hFFFF;
        tick();
        chk("set_ffff", pc, 16'hFFFF);
        code = 3'b010; mem_ready = 1'b1;
        tick();
        chk("wrap", pc, 16'h0000);

        // reset during bubble after interrupt
        data_bus = 16'h0000; code = 3'b001;
        tick();
        code = 3'b010; interrupt = 1'b1; int_vector = 16'h0400;
        tick();
        interrupt = 1'b0;
        chk("pre_rst_pc", pc, 16'h0400);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 16'h0000);
        chk("mid_rst_active", {15'd0, int_active}, 16'd0);
        chk("mid_rst_valid", {15'd0, addr_valid}, 16'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_valid", {15'd0, addr_valid}, 16'd1);
        tick();
        chk("post_rst_inc", pc, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
